ibex_data_sram_bridge: RTL
==========================

// Module: ibex_data_sram_bridge
// PURPOSE
//  Downstream slave of the load/store unit's data port: converts req/gnt/rvalid handshake into
//  accesses to one single-port synchronous data SRAM (1-cycle read latency). Inserts configurable
//  grant wait states, flags out-of-range addresses as bus errors, logs first error address.
// PARAMETERS
//  ADDR_BASE    32'h0010_0000  byte base address of SRAM window (MEM_WORDS*4 aligned)
//  MEM_WORDS    4096           SRAM depth in 32-bit words, power of 2; AW = $clog2(MEM_WORDS)
//  WAIT_CYCLES  0              cycles req is held before gnt (0..15)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   async active-low reset
//  data_req_i     in   1   request from LSU, held until gnt
//  data_addr_i    in   32  byte address
//  data_we_i      in   1   1=store, 0=load
//  data_be_i      in   4   byte enables
//  data_wdata_i   in   32  store data, pre-aligned by LSU
//  data_gnt_o     out  1   request accepted this cycle
//  data_rvalid_o  out  1   response valid (exactly one per gnt)
//  data_err_o     out  1   error, asserted only together with data_gnt_o
//  data_rdata_o   out  32  load data, valid with rvalid
//  sram_req_o     out  1   SRAM access strobe
//  sram_we_o      out  1   SRAM write enable
//  sram_addr_o    out  AW  SRAM word address
//  sram_be_o      out  4   SRAM byte write mask
//  sram_wdata_o   out  32  SRAM write data
//  sram_rdata_i   in   32  SRAM read data, valid cycle after sram_req_o
//  err_valid_o    out  1   sticky: an error has occurred
//  err_addr_o     out  32  byte address of first error since last clear
//  err_clr_i      in   1   clears err_valid_o/err_addr_o
// BEHAVIOUR
//  - Reset: all outputs 0; wait_cnt=0; resp_pend_q=0; err_valid=0; err_addr=0.
//  - in_range = (data_addr_i - ADDR_BASE) < MEM_WORDS*4, 32-bit unsigned compare (wrap below base
//    = out of range). sram_addr_o = (data_addr_i - ADDR_BASE)[AW+1:2].
//  - wait_cnt (4b): gnt = req && wait_cnt==WAIT_CYCLES (combinational). wait_cnt++ when req&&!gnt;
//    cleared on gnt or when req low. WAIT_CYCLES=0 -> gnt same cycle as req.
//  - On gnt && in_range: sram_req_o=1, sram_we_o=we, be/wdata pass through (be=0 passed as-is).
//  - On gnt && !in_range: data_err_o=1, sram_req_o=0 (no SRAM side effect).
//  - sram_req_o is 0 whenever gnt is 0.
//  - Response FSM, states IDLE/RESP: gnt -> RESP, latch we_q/err_q; RESP -> rvalid=1 for 1 cycle;
//    in RESP a new gnt stays RESP, else -> IDLE. Fixed latency gnt->rvalid = 1 cycle.
//  - rdata_o = sram_rdata_i if RESP && !we_q && !err_q, else 32'h0.
//  - Max one outstanding: a new gnt can coincide only with rvalid of the previous one; with
//    WAIT_CYCLES=0 back-to-back accesses give gnt every cycle and rvalid every following cycle.
//  - Error log: on err gnt and !err_valid: err_valid<=1, err_addr<=data_addr_i. Later errors do not
//    overwrite. err_clr_i same cycle as new error: clear wins, error not logged.
//  - Req dropped before gnt (protocol violation): wait_cnt cleared, no access, no response.
//  - Reset mid-transaction: pending rvalid discarded, state IDLE, no SRAM access.
// TESTING
//  - WAIT_CYCLES=0, SW 0x1234_5678 @0x0010_0008 be=1111 -> gnt c0, sram_addr=2 we=1, rvalid c1.
//  - Then LW @0x0010_0008 -> gnt c0, rvalid c1, rdata=0x1234_5678; SB be=0010 changes byte 1 only.
//  - WAIT_CYCLES=3, req held from c0 -> gnt c3 only, rvalid c4; no sram_req_o c0-c2.
//  - LW @0x0000_0FFC then @0x0010_4000 -> err with gnt, no sram_req, rvalid rdata=0, err_addr=
//    0x0000_0FFC kept; err_clr_i -> err_valid=0.
//  - Misaligned LW split by LSU (two back-to-back reqs, adjacent words) -> gnt/rvalid per request,
//    rvalid pulses c1,c2; async reset in RESP -> rvalid never asserted, outputs 0.

Source files
------------

// File: rtl/ibex_data_sram_bridge.sv
// Bridges the LSU data port (req/gnt/rvalid) onto one single-port synchronous SRAM with
// optional grant wait states, out-of-range bus errors and a sticky first-error address log.
module ibex_data_sram_bridge #(
    parameter logic [31:0] ADDR_BASE   = 32'h0010_0000,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_req_i,
    input  logic [31:0]   data_addr_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic          data_err_o,
    output logic [31:0]   data_rdata_o,
    output logic          sram_req_o,
    output logic          sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [3:0]    sram_be_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i,
    output logic          err_valid_o,
    output logic [31:0]   err_addr_o,
    input  logic          err_clr_i
);

    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_VAL  = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        err_q;
    logic        err_valid_q;
    logic [31:0] err_addr_q;

    logic [31:0] offset;
    logic        in_range;
    logic        gnt;
    logic        access;

    // Subtracting the base first makes addresses below the window wrap high and fail the compare.
    assign offset   = data_addr_i - ADDR_BASE;
    assign in_range = offset < WIN_BYTES;
    assign gnt      = data_req_i && (wait_cnt == WAIT_VAL);
    assign access   = gnt && in_range;

    assign data_gnt_o   = gnt;
    assign data_err_o   = gnt && !in_range;
    assign sram_req_o   = access;
    assign sram_we_o    = access && data_we_i;
    assign sram_addr_o  = access ? offset[AW+1:2] : '0;
    assign sram_be_o    = access ? data_be_i : 4'h0;
    assign sram_wdata_o = access ? data_wdata_i : 32'h0;

    assign err_valid_o  = err_valid_q;
    assign err_addr_o   = err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'h0;
        end else if (!data_req_i || gnt) begin
            wait_cnt <= 4'h0;
        end else begin
            wait_cnt <= wait_cnt + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                we_q  <= data_we_i;
                err_q <= !in_range;
            end
        end
    end

    // A grant always yields exactly one rvalid the following cycle, so RESP is re-entered on
    // back-to-back grants and left otherwise.
    always_comb begin
        state_d       = IDLE;
        data_rvalid_o = 1'b0;
        data_rdata_o  = 32'h0;
        if (gnt) begin
            state_d = RESP;
        end
        if (state_q == RESP) begin
            data_rvalid_o = 1'b1;
            if (!we_q && !err_q) begin
                data_rdata_o = sram_rdata_i;
            end
        end
    end

    // Clear takes priority over a coincident new error, which is then not recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
        end else if (data_err_o && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= data_addr_i;
        end
    end

endmodule
